bip_sequencer: RTL and testbench
================================

# bip_sequencer

Fetch/execute controller for the BIP processor core. It owns the program counter and instruction register, fetches instructions from the synchronous program memory, and presents opcode and operand with a one-cycle valid strobe to the opcode decoder. It uses the decoder's PC-write enable to advance the PC, and stops on HLT. Run, single-step and restart are driven by the debug/UART unit.

## Interface
- PC_WIDTH, 11, program-memory address width.
- OPCODE_WIDTH, 5, opcode field width (instruction MSBs).
- OPERAND_WIDTH, 11, operand field width (instruction LSBs).
- CNT_WIDTH, 32, retired-instruction counter width.
- i_clk  in  1  single clock; all state on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- i_step_mode  in  1  1 = pause after every instruction; sampled at end of EXEC.
- i_step  in  1  one-cycle pulse; releases PAUSE.
- o_imem_rd  out  1  program-memory read enable.
- o_pc  out  PC_WIDTH  program counter, also the program-memory address.
- i_insn  in  OPCODE_WIDTH+OPERAND_WIDTH  memory read data, valid the cycle after o_imem_rd.
- o_opcode  out  OPCODE_WIDTH  IR opcode field.
- o_operand  out  OPERAND_WIDTH  IR operand field, to the data-RAM address and sign-extender.
- o_valid  out  1  to decoder i_valid; high only in EXEC.
- i_write_pc  in  1  from decoder; PC increments at end of EXEC when high.
- o_halted  out  1  high in HALT.
- o_busy  out  1  high in FETCH, DECODE and EXEC.
- o_insn_count  out  CNT_WIDTH  instructions retired since the last reset or restart.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, PAUSE, HALT.
- IDLE: waits for i_start, then goes to FETCH. PC and counter are not cleared, so the PC is 0 after reset.
- FETCH: o_imem_rd=1 with address o_pc. Always goes to DECODE.
- DECODE: IR <= i_insn. Always goes to EXEC.
- EXEC: o_valid=1. The decoder and datapath act combinationally this cycle; the accumulator and RAM write at the closing edge.
  - If i_write_pc=1, PC <= PC+1, modulo 2^PC_WIDTH (wraps to 0).
  - If o_opcode == HLT (0), go to HALT.
  - Otherwise, go to PAUSE if i_step_mode=1, else FETCH.
  - o_insn_count increments on every EXEC, HLT included, and saturates at all-ones.
- PAUSE: i_step goes to FETCH; i_start is ignored.
- HALT: o_halted=1. i_start clears PC, IR and o_insn_count to 0 and goes to FETCH.
- i_start in FETCH, DECODE, EXEC or PAUSE has no effect. i_step outside PAUSE has no effect.
- An undefined opcode is executed as a no-op. The decoder deasserts i_write_pc for it, so the PC does not advance and the same instruction is refetched indefinitely; only reset or external intervention recovers.

## Timing
- Reset (asynchronous, immediate): state IDLE, PC 0, IR 0, o_insn_count 0. All outputs 0: o_valid, o_imem_rd, o_halted, o_busy, o_opcode, o_operand.
- Reset asserted mid-EXEC cancels the PC and counter update. Datapath writes from that edge are the datapath's own concern.
- Each instruction takes 3 cycles (FETCH, DECODE, EXEC), so throughput is 1 instruction per 3 cycles in run mode.
- i_start to the first o_imem_rd: 1 cycle.
- o_valid is high for exactly 1 cycle per instruction. o_opcode and o_operand are stable from DECODE+1 until the next DECODE.
- The new o_pc value is visible in the cycle after EXEC, which is the next FETCH, so the fetch address always reflects the update.
- All outputs are registered or decoded directly from the state register; there is no combinational path from any input to any output.

## Structure
- Shared package bip_pkg holds:
  - opcode constants HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI (5-bit);
  - the sequencer state encoding;
  - default field widths.
  - The opcode decoder imports the same constants.
- One natural sub-module, bip_program_counter: width-parameterised register with synchronous clear, increment enable and asynchronous active-low reset.

## Test plan
- Reset: assert i_rst_n=0 mid-FETCH → all outputs 0 in the same cycle; after release, state is IDLE and o_pc=0.
- Run to halt with a reference decoder model; program LDI 5, ADDI 3, HLT.
  - After i_start, o_valid pulses every 3 cycles with opcodes 3, 5, 0.
  - o_pc runs 0, 1, 2 and stays at 2.
  - o_halted=1 and o_insn_count=3.
- Step mode: i_step_mode=1, same program.
  - After each EXEC the sequencer holds in PAUSE with o_busy=0.
  - No o_imem_rd until i_step.
  - i_start during PAUSE is ignored.
- Restart: i_start in HALT → o_pc=0, o_insn_count=0, and the program re-executes identically.
- Wrap: with PC_WIDTH=3 and memory filled with ADDI 1 (no HLT), after 8 instructions o_pc returns to 0. With CNT_WIDTH=3, o_insn_count saturates at 7.
- Undefined opcode 5'b11111 at address 0 → o_valid pulses repeatedly, o_pc stays 0, o_insn_count increments.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP core: opcode constants, sequencer state
// encoding and default field widths. Imported by the sequencer and decoder.
package bip_pkg;

  localparam int unsigned PC_WIDTH_DEF      = 11;
  localparam int unsigned OPCODE_WIDTH_DEF  = 5;
  localparam int unsigned OPERAND_WIDTH_DEF = 11;
  localparam int unsigned CNT_WIDTH_DEF     = 32;

  // Instruction opcodes (instruction MSBs)
  localparam logic [4:0] HLT  = 5'd0;
  localparam logic [4:0] STO  = 5'd1;
  localparam logic [4:0] LD   = 5'd2;
  localparam logic [4:0] LDI  = 5'd3;
  localparam logic [4:0] ADD  = 5'd4;
  localparam logic [4:0] ADDI = 5'd5;
  localparam logic [4:0] SUB  = 5'd6;
  localparam logic [4:0] SUBI = 5'd7;

  // Fetch/execute sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_e;

  // True for any opcode the core implements; everything else is a no-op
  function automatic logic is_defined_op(input logic [4:0] op);
    return (op <= SUBI);
  endfunction

endpackage

// File: rtl/bip_program_counter.sv
// Program counter register.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (advance by one, wrapping), q (current count).
module bip_program_counter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // Wraps naturally modulo 2^WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bip_sequencer.sv
// Fetch/execute controller for the BIP core. Owns PC and IR, fetches from the
// synchronous program memory and hands opcode/operand to the decoder with a
// one-cycle valid strobe. Run, single-step and restart come from debug/UART.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start, i_step_mode,     run control
//   i_step
//   o_imem_rd, o_pc, i_insn   program-memory read port (1-cycle latency)
//   o_opcode, o_operand,      IR fields and execute strobe to the decoder
//   o_valid
//   i_write_pc                decoder request to advance the PC
//   o_halted, o_busy          status
//   o_insn_count              retired instructions, saturating
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int unsigned PC_WIDTH      = PC_WIDTH_DEF,
  parameter int unsigned OPCODE_WIDTH  = OPCODE_WIDTH_DEF,
  parameter int unsigned OPERAND_WIDTH = OPERAND_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic                                  i_step_mode,
  input  logic                                  i_step,
  output logic                                  o_imem_rd,
  output logic [PC_WIDTH-1:0]                   o_pc,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] i_insn,
  output logic [OPCODE_WIDTH-1:0]               o_opcode,
  output logic [OPERAND_WIDTH-1:0]              o_operand,
  output logic                                  o_valid,
  input  logic                                  i_write_pc,
  output logic                                  o_halted,
  output logic                                  o_busy,
  output logic [CNT_WIDTH-1:0]                  o_insn_count
);

  localparam int unsigned INSN_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;

  seq_state_e state_q, state_d;

  logic [INSN_WIDTH-1:0] ir_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  restart;
  logic                  pc_inc;
  logic                  cnt_inc;

  assign o_opcode     = ir_q[INSN_WIDTH-1:OPERAND_WIDTH];
  assign o_operand    = ir_q[OPERAND_WIDTH-1:0];
  assign o_insn_count = cnt_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    pc_inc  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_inc = 1'b1;
        pc_inc  = i_write_pc;
        if (o_opcode == OPCODE_WIDTH'(HLT)) begin
          state_d = ST_HALT;
        end else if (i_step_mode) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_PAUSE: begin
        if (i_step) state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (i_start) begin
          restart = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they line up with state_q
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_imem_rd <= 1'b0;
      o_valid   <= 1'b0;
      o_halted  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_imem_rd <= (state_d == ST_FETCH);
      o_valid   <= (state_d == ST_EXEC);
      o_halted  <= (state_d == ST_HALT);
      o_busy    <= (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                   (state_d == ST_EXEC);
    end
  end

  // Instruction register: memory data arrives in DECODE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ir_q <= '0;
    end else if (restart) begin
      ir_q <= '0;
    end else if (state_q == ST_DECODE) begin
      ir_q <= i_insn;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  bip_program_counter #(
    .WIDTH (PC_WIDTH)
  ) u_pc (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (restart),
    .inc   (pc_inc),
    .q     (o_pc)
  );

endmodule

// File: tb/tb_bip_sequencer.sv
// Directed bench for bip_sequencer: a default-width instance runs the main
// program scenarios; a narrow instance (3-bit PC and counter) covers wrap and
// saturation. Program memory and decoder are small bench models.
module tb_bip_sequencer;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BAD  = 5'd31;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Main instance
  logic        start, step_mode, step;
  logic        imem_rd, valid, write_pc, halted, busy;
  logic [10:0] pc, operand;
  logic [4:0]  opcode;
  logic [15:0] insn;
  logic [31:0] insn_count;
  logic [15:0] mem [0:2047];

  // Narrow instance
  logic        s_start;
  logic        s_imem_rd, s_valid, s_write_pc, s_halted, s_busy;
  logic [2:0]  s_pc, s_count;
  logic [10:0] s_operand;
  logic [4:0]  s_opcode;
  logic [15:0] s_insn;

  always #5 clk = ~clk;

  bip_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_step_mode  (step_mode),
    .i_step       (step),
    .o_imem_rd    (imem_rd),
    .o_pc         (pc),
    .i_insn       (insn),
    .o_opcode     (opcode),
    .o_operand    (operand),
    .o_valid      (valid),
    .i_write_pc   (write_pc),
    .o_halted     (halted),
    .o_busy       (busy),
    .o_insn_count (insn_count)
  );

  bip_sequencer #(
    .PC_WIDTH  (3),
    .CNT_WIDTH (3)
  ) dut_small (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (s_start),
    .i_step_mode  (1'b0),
    .i_step       (1'b0),
    .o_imem_rd    (s_imem_rd),
    .o_pc         (s_pc),
    .i_insn       (s_insn),
    .o_opcode     (s_opcode),
    .o_operand    (s_operand),
    .o_valid      (s_valid),
    .i_write_pc   (s_write_pc),
    .o_halted     (s_halted),
    .o_busy       (s_busy),
    .o_insn_count (s_count)
  );

  // Synchronous program memories
  always_ff @(posedge clk) begin
    if (imem_rd) insn <= mem[pc];
    if (s_imem_rd) s_insn <= {OP_ADDI, 11'd1};
  end

  // Reference decoder: defined non-HLT opcodes advance the PC
  assign write_pc   = valid && (opcode != OP_HLT) && (opcode <= 5'd7);
  assign s_write_pc = s_valid && (s_opcode != OP_HLT) && (s_opcode <= 5'd7);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the FETCH cycle; leaves one cycle after EXEC
  task automatic expect_insn(input logic [10:0] exp_pc, input logic [4:0] exp_op,
                             input logic [10:0] exp_arg);
    check("fetch_rd",    64'(imem_rd), 64'(1));
    check("fetch_pc",    64'(pc), 64'(exp_pc));
    check("fetch_busy",  64'(busy), 64'(1));
    tick();
    check("decode_rd",   64'(imem_rd), 64'(0));
    check("decode_vld",  64'(valid), 64'(0));
    tick();
    check("exec_vld",    64'(valid), 64'(1));
    check("exec_op",     64'(opcode), 64'(exp_op));
    check("exec_arg",    64'(operand), 64'(exp_arg));
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; s_start = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = {OP_HLT, 11'd0};
    mem[0] = {OP_LDI, 11'd5};
    mem[1] = {OP_ADDI, 11'd3};
    mem[2] = {OP_HLT, 11'd0};

    // Reset values
    repeat (2) tick();
    check("rst_valid",  64'(valid), 64'(0));
    check("rst_rd",     64'(imem_rd), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_pc",     64'(pc), 64'(0));
    check("rst_op",     64'(opcode), 64'(0));
    check("rst_arg",    64'(operand), 64'(0));
    check("rst_cnt",    64'(insn_count), 64'(0));
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-FETCH clears outputs without a clock edge
    pulse_start();
    check("midf_rd_pre", 64'(imem_rd), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midf_rd",   64'(imem_rd), 64'(0));
    check("midf_busy", 64'(busy), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("midf_idle_pc",   64'(pc), 64'(0));
    check("midf_idle_busy", 64'(busy), 64'(0));
    check("midf_idle_rd",   64'(imem_rd), 64'(0));

    // Run to halt
    pulse_start();
    expect_insn(11'd0, OP_LDI, 11'd5);
    expect_insn(11'd1, OP_ADDI, 11'd3);
    expect_insn(11'd2, OP_HLT, 11'd0);
    check("run_halted", 64'(halted), 64'(1));
    check("run_busy",   64'(busy), 64'(0));
    check("run_pc",     64'(pc), 64'(2));
    check("run_cnt",    64'(insn_count), 64'(3));
    repeat (3) tick();
    check("halt_hold_pc", 64'(pc), 64'(2));
    check("halt_hold",    64'(halted), 64'(1));

    // Restart in step mode
    step_mode = 1'b1;
    pulse_start();
    check("restart_cnt", 64'(insn_count), 64'(0));
    check("restart_pc",  64'(pc), 64'(0));
    expect_insn(11'd0, OP_LDI, 11'd5);
    check("pause_busy", 64'(busy), 64'(0));
    check("pause_rd",   64'(imem_rd), 64'(0));
    check("pause_halt", 64'(halted), 64'(0));
    check("pause_cnt",  64'(insn_count), 64'(1));
    repeat (3) tick();
    check("pause_hold_rd", 64'(imem_rd), 64'(0));
    pulse_start();
    check("pause_start_rd", 64'(imem_rd), 64'(0));
    tick();
    check("pause_start_rd2",  64'(imem_rd), 64'(0));
    check("pause_start_busy", 64'(busy), 64'(0));
    pulse_step();
    expect_insn(11'd1, OP_ADDI, 11'd3);
    check("pause2_busy", 64'(busy), 64'(0));
    pulse_step();
    expect_insn(11'd2, OP_HLT, 11'd0);
    check("step_halted", 64'(halted), 64'(1));
    check("step_cnt",    64'(insn_count), 64'(3));
    check("step_pc",     64'(pc), 64'(2));

    // Undefined opcode is refetched forever
    step_mode = 1'b0;
    mem[0] = {OP_BAD, 11'd7};
    pulse_start();
    for (int i = 0; i < 3; i++) expect_insn(11'd0, OP_BAD, 11'd7);
    check("undef_cnt", 64'(insn_count), 64'(3));
    check("undef_pc",  64'(pc), 64'(0));
    check("undef_halted", 64'(halted), 64'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Narrow instance: PC wraps at 8, counter saturates at 7
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("wrap_pc",  64'(s_pc), 64'(i % 8));
      check("wrap_cnt", 64'(s_count), 64'((i < 7) ? i : 7));
      tick();
      tick();
      check("wrap_vld", 64'(s_valid), 64'(1));
      tick();
    end
    check("wrap_pc_end",  64'(s_pc), 64'(2));
    check("wrap_cnt_end", 64'(s_count), 64'(7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
